add_simd_sat: RTL and testbench

Parametrised SIMD element-wise adder for the image datapath. It sums two packed vectors of signed lanes, such as residual or shortcut feature maps. Each lane sum can be rounded and right-shifted for requantisation, then either saturated or wrapped back to lane width. A valid/ready handshake allows backpressure from downstream, and a saturation-event counter is kept for calibration readback. It sits between the two feature-map producers and the output/store stage, and replaces fixed-latency, no-backpressure lane adders.

---
 rtl/add_simd_sat.sv | 152 +++++++++++++++
 tb/tb_add_simd_sat.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_simd_sat.sv
// SIMD lane adder: sum, round-half-up shift, then clamp or wrap, in a 3-stage pipeline with backpressure.
// sat_cnt accumulates clamped lanes over output transfers and sticks at its maximum value.
module add_simd_sat #(
    parameter int LANES   = 8,
    parameter int WIDTH   = 16,
    parameter int SHIFT_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] data_one_in,
    input  logic [LANES*WIDTH-1:0] data_two_in,
    input  logic                   cfg_sat,
    input  logic [SHIFT_W-1:0]     cfg_shift,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       sat_flag,
    output logic [CNT_W-1:0]       sat_cnt,
    input  logic                   cnt_clr
);
    localparam int SW = WIDTH + 1;
    localparam int RW = WIDTH + 2;
    localparam logic signed [RW-1:0] MAX_V = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] MIN_V = {3'b111, {(WIDTH-1){1'b0}}};

    logic                         s1_valid_q, s1_valid_d;
    logic [LANES-1:0][SW-1:0]     s1_sum_q, s1_sum_d;
    logic                         s1_sat_q, s1_sat_d;
    logic [SHIFT_W-1:0]           s1_shift_q, s1_shift_d;
    logic                         s2_valid_q, s2_valid_d;
    logic [LANES-1:0][RW-1:0]     s2_r_q, s2_r_d;
    logic                         s2_sat_q, s2_sat_d;
    logic                         s3_valid_q, s3_valid_d;
    logic [LANES-1:0][WIDTH-1:0]  s3_data_q, s3_data_d;
    logic [LANES-1:0]             s3_flag_q, s3_flag_d;
    logic [CNT_W-1:0]             sat_cnt_q, sat_cnt_d;

    logic                         advance;
    logic [WIDTH-1:0]             op_a, op_b;
    logic signed [RW-1:0]         ext, rnd_sum, r_lane;
    logic [CNT_W-1:0]             pop;
    logic [CNT_W:0]               cnt_sum;

    // Handshake: a beat moves on a rising edge when valid & ready are both high; the whole
    // pipeline advances together whenever the output stage is empty or being drained.
    assign advance   = !s3_valid_q || out_ready;
    assign in_ready  = advance;
    assign out_valid = s3_valid_q;
    assign data_out  = s3_data_q;
    assign sat_flag  = s3_flag_q;
    assign sat_cnt   = sat_cnt_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sum_d   = s1_sum_q;
        s1_sat_d   = s1_sat_q;
        s1_shift_d = s1_shift_q;
        s2_valid_d = s2_valid_q;
        s2_r_d     = s2_r_q;
        s2_sat_d   = s2_sat_q;
        s3_valid_d = s3_valid_q;
        s3_data_d  = s3_data_q;
        s3_flag_d  = s3_flag_q;
        op_a       = '0;
        op_b       = '0;
        ext        = '0;
        rnd_sum    = '0;
        r_lane     = '0;
        if (advance) begin
            s1_valid_d = in_valid;
            s1_sat_d   = cfg_sat;
            // Oversized shifts are clamped on entry so later stages only see 0..WIDTH.
            s1_shift_d = (cfg_shift > SHIFT_W'(WIDTH)) ? SHIFT_W'(WIDTH) : cfg_shift;
            for (int i = 0; i < LANES; i++) begin
                op_a        = data_one_in[WIDTH*i +: WIDTH];
                op_b        = data_two_in[WIDTH*i +: WIDTH];
                s1_sum_d[i] = {op_a[WIDTH-1], op_a} + {op_b[WIDTH-1], op_b};
            end

            s2_valid_d = s1_valid_q;
            s2_sat_d   = s1_sat_q;
            for (int i = 0; i < LANES; i++) begin
                ext = {s1_sum_q[i][SW-1], s1_sum_q[i]};
                if (s1_shift_q == '0) begin
                    s2_r_d[i] = ext;
                end else begin
                    rnd_sum   = ext + (RW'(1) << (s1_shift_q - SHIFT_W'(1)));
                    s2_r_d[i] = rnd_sum >>> s1_shift_q;
                end
            end

            s3_valid_d = s2_valid_q;
            for (int i = 0; i < LANES; i++) begin
                r_lane       = s2_r_q[i];
                s3_data_d[i] = r_lane[WIDTH-1:0];
                s3_flag_d[i] = 1'b0;
                if (s2_sat_q && (r_lane > MAX_V)) begin
                    s3_data_d[i] = MAX_V[WIDTH-1:0];
                    s3_flag_d[i] = 1'b1;
                end else if (s2_sat_q && (r_lane < MIN_V)) begin
                    s3_data_d[i] = MIN_V[WIDTH-1:0];
                    s3_flag_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + CNT_W'(s3_flag_q[i]);
        end
        cnt_sum   = {1'b0, sat_cnt_q} + {1'b0, pop};
        sat_cnt_d = sat_cnt_q;
        if (cnt_clr) begin
            sat_cnt_d = '0;
        end else if (s3_valid_q && out_ready) begin
            sat_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_sat_q   <= 1'b0;
            s1_shift_q <= '0;
            s2_valid_q <= 1'b0;
            s2_r_q     <= '0;
            s2_sat_q   <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_data_q  <= '0;
            s3_flag_q  <= '0;
            sat_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_sat_q   <= s1_sat_d;
            s1_shift_q <= s1_shift_d;
            s2_valid_q <= s2_valid_d;
            s2_r_q     <= s2_r_d;
            s2_sat_q   <= s2_sat_d;
            s3_valid_q <= s3_valid_d;
            s3_data_q  <= s3_data_d;
            s3_flag_q  <= s3_flag_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end
endmodule

// File: tb/tb_add_simd_sat.sv
// Bench for add_simd_sat: arithmetic lane model with a scoreboard queue, plus directed literal vectors.
module tb_add_simd_sat;
  localparam int L = 8;
  localparam int W = 16;
  localparam int CW = 4;
  localparam int CNT_MAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [L*W-1:0] data_one_in = '0;
  logic [L*W-1:0] data_two_in = '0;
  logic cfg_sat = 1'b0;
  logic [4:0] cfg_shift = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [L*W-1:0] data_out;
  logic [L-1:0] sat_flag;
  logic [CW-1:0] sat_cnt;
  logic cnt_clr = 1'b0;

  add_simd_sat #(.LANES(L), .WIDTH(W), .SHIFT_W(5), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_one_in(data_one_in), .data_two_in(data_two_in),
    .cfg_sat(cfg_sat), .cfg_shift(cfg_shift),
    .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .sat_flag(sat_flag), .sat_cnt(sat_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  bit checking = 0;
  logic [L*W-1:0] exp_q[$];
  logic [L-1:0] expf_q[$];
  int cnt_exp = 0;
  bit held = 0;
  logic [L*W-1:0] held_data;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Lane arithmetic straight from the rules: integer sum, floor((s + half) / 2^n), clamp or wrap.
  function automatic void model(input logic [L*W-1:0] a, input logic [L*W-1:0] b,
                                input logic sat, input logic [4:0] sh,
                                output logic [L*W-1:0] d, output logic [L-1:0] f);
    int s;
    int n;
    d = '0;
    f = '0;
    n = (int'(sh) > W) ? W : int'(sh);
    for (int i = 0; i < L; i++) begin
      s = int'($signed(a[i*W +: W])) + int'($signed(b[i*W +: W]));
      if (n > 0) s = (s + (1 << (n - 1))) >>> n;
      if (sat && s > 32767) begin s = 32767; f[i] = 1'b1; end
      else if (sat && s < -32768) begin s = -32768; f[i] = 1'b1; end
      d[i*W +: W] = s[W-1:0];
    end
  endfunction

  function automatic logic [L*W-1:0] mk(input logic [15:0] l0, input logic [15:0] l1, input logic [15:0] l2);
    logic [L*W-1:0] v;
    v = '0;
    v[15:0] = l0;
    v[31:16] = l1;
    v[47:32] = l2;
    return v;
  endfunction

  // Scoreboard: compare on every falling edge, then predict what the next rising edge does.
  always @(negedge clk) begin
    logic [L*W-1:0] md;
    logic [L-1:0] mf;
    int pc;
    if (checking) begin
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 1'b0);
        end else begin
          chk("sb_data", data_out, exp_q[0]);
          chk("sb_flag", sat_flag, expf_q[0]);
        end
        if (held) chk("hold_data", data_out, held_data);
      end
      chk("in_ready_rule", in_ready, (!out_valid) || out_ready);
      chk("sb_sat_cnt", sat_cnt, cnt_exp);
      held = out_valid && !out_ready;
      held_data = data_out;
      if (rst) begin
        exp_q.delete();
        expf_q.delete();
        cnt_exp = 0;
        held = 0;
      end else begin
        pc = 0;
        if (out_valid && out_ready && exp_q.size() > 0) begin
          for (int i = 0; i < L; i++) pc += int'(expf_q[0][i]);
          void'(exp_q.pop_front());
          void'(expf_q.pop_front());
          delivered++;
        end
        if (cnt_clr) cnt_exp = 0;
        else cnt_exp = (cnt_exp + pc > CNT_MAX) ? CNT_MAX : cnt_exp + pc;
        if (in_valid && in_ready) begin
          model(data_one_in, data_two_in, cfg_sat, cfg_shift, md, mf);
          exp_q.push_back(md);
          expf_q.push_back(mf);
        end
      end
    end
  end

  // Drive one beat into an idle pipeline with out_ready high; report edges until out_valid.
  task automatic send_beat(input logic [L*W-1:0] a, input logic [L*W-1:0] b, input logic sat,
                           input logic [4:0] sh, output int lat, output logic [L*W-1:0] d,
                           output logic [L-1:0] f);
    int n;
    data_one_in = a; data_two_in = b; cfg_sat = sat; cfg_shift = sh; in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    if (n >= 50) chk("accept_timeout", 1'b0, 1'b1);
    @(posedge clk); #1; in_valid = 1'b0;
    lat = 0; d = '0; f = '0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 20);
    if (!out_valid) chk("out_timeout", 1'b0, 1'b1);
    d = data_out; f = sat_flag;
    @(posedge clk); #1;
  endtask

  function automatic void gen(input int k, output logic [L*W-1:0] a, output logic [L*W-1:0] b,
                              output logic sat, output logic [4:0] sh);
    for (int i = 0; i < L; i++) begin
      a[i*W +: W] = 16'((k * 4099 + i * 7919) ^ (i[0] ? 16'h7F00 : 16'h8100));
      b[i*W +: W] = 16'((k * 1231 + i * 3001) ^ (i[1] ? 16'h7000 : 16'h9000));
    end
    sat = k[0];
    sh = k[1] ? 5'd2 : 5'd0;
  endfunction

  task automatic stream(input int n, input int base, input int st, input int sl, output int cyc);
    int k;
    logic acc;
    logic [L*W-1:0] a, b;
    logic s;
    logic [4:0] sh;
    k = 0; cyc = 0;
    while (k < n && cyc < 200) begin
      out_ready = !(cyc >= st && cyc < st + sl);
      gen(base + k, a, b, s, sh);
      data_one_in = a; data_two_in = b; cfg_sat = s; cfg_shift = sh; in_valid = 1'b1;
      @(negedge clk);
      if (!out_ready) chk("stall_in_ready", in_ready, 1'b0);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) k++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while ((exp_q.size() != 0 || out_valid) && n < 50);
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int lat, cyc, d0;
    logic [L*W-1:0] d, a, b;
    logic [L-1:0] f;
    logic s;
    logic [4:0] sh;

    @(posedge clk);
    checking = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_data_out", data_out, '0);
    chk("rst_sat_flag", sat_flag, '0);
    chk("rst_sat_cnt", sat_cnt, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Saturating add, shift 0
    send_beat(mk(16'h7FFF, 16'h8000, 16'h0), mk(16'h0001, 16'hFFFF, 16'h0), 1'b1, 5'd0, lat, d, f);
    chk("latency", lat, 3);
    chk("sat_lane0", d[15:0], 16'h7FFF);
    chk("sat_lane1", d[31:16], 16'h8000);
    chk("sat_flags", f, 8'b0000_0011);
    @(negedge clk);
    chk("sat_cnt_after", sat_cnt, 2);
    @(posedge clk); #1;

    // Same operands, wrapping
    send_beat(mk(16'h7FFF, 16'h8000, 16'h0), mk(16'h0001, 16'hFFFF, 16'h0), 1'b0, 5'd0, lat, d, f);
    chk("wrap_lane0", d[15:0], 16'h8000);
    chk("wrap_lane1", d[31:16], 16'h7FFF);
    chk("wrap_flags", f, 8'b0);
    @(negedge clk);
    chk("wrap_sat_cnt", sat_cnt, 2);
    @(posedge clk); #1;

    // Rounding
    send_beat(mk(16'd3, 16'hFFFD, 16'd1), '0, 1'b1, 5'd1, lat, d, f);
    chk("rnd_3", d[15:0], 16'd2);
    chk("rnd_m3", d[31:16], 16'hFFFF);
    chk("rnd_1", d[47:32], 16'd1);
    send_beat(mk(16'h7FFF, 16'h8000, 16'h0), mk(16'h7FFF, 16'h8000, 16'h0), 1'b1, 5'd16, lat, d, f);
    chk("sh16_pos", d[15:0], 16'd1);
    chk("sh16_neg", d[31:16], 16'hFFFF);
    send_beat(mk(16'h7FFF, 16'h0, 16'h0), mk(16'h7FFF, 16'h0, 16'h0), 1'b1, 5'd31, lat, d, f);
    chk("sh31_as_16", d[15:0], 16'd1);

    // Per-beat config, back to back at full rate
    d0 = delivered;
    stream(4, 0, 1000, 0, cyc);
    chk("tput_in_cycles", cyc, 4);
    repeat (3) @(posedge clk);
    #1;
    chk("tput_out_count", delivered - d0, 4);
    drain();

    // Backpressure mid-stream
    d0 = delivered;
    stream(10, 20, 4, 5, cyc);
    chk("bp_in_cycles", cyc, 15);
    drain();
    chk("bp_delivered", delivered - d0, 10);

    // Counter sticks at maximum, then explicit clear
    for (int k = 0; k < 3; k++) begin
      send_beat({L{16'h7FFF}}, {L{16'h7FFF}}, 1'b1, 5'd0, lat, d, f);
      chk("all_flags", f, 8'hFF);
    end
    @(negedge clk);
    chk("cnt_sticky", sat_cnt, CNT_MAX);
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clr_alone", sat_cnt, 0);
    @(posedge clk); #1;
    send_beat({L{16'h7FFF}}, {L{16'h7FFF}}, 1'b1, 5'd0, lat, d, f);

    // Reset with three beats in flight
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      gen(40 + k, a, b, s, sh);
      data_one_in = a; data_two_in = b; cfg_sat = 1'b1; cfg_shift = sh; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("inflight_valid", out_valid, 1'b1);
    pulse_rst();
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_cnt", sat_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_data", data_out, '0);
    for (int k = 0; k < 4; k++) begin
      chk("mid_rst_no_valid", out_valid, 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1;

    // Clear coincident with a saturating transfer
    send_beat(mk(16'h7FFF, 16'h8000, 16'h0), mk(16'h0001, 16'hFFFF, 16'h0), 1'b1, 5'd0, lat, d, f);
    @(negedge clk);
    chk("cnt_before_clr", sat_cnt, 2);
    @(posedge clk); #1;
    data_one_in = mk(16'h7FFF, 16'h8000, 16'h0);
    data_two_in = mk(16'h0001, 16'hFFFF, 16'h0);
    cfg_sat = 1'b1; cfg_shift = 5'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("clr_xfer_valid", out_valid, 1'b1);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_with_xfer", sat_cnt, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
